execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width.
REQ-002 SHALL have parameter MUL_CYCLES, default 16, multiply iterations (one bit per cycle).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port CTRL_ID  input  4  decoded opcode from decode.
REQ-007 SHALL have port OPA_ID  input  DATA_W  source operand A.
REQ-008 SHALL have port OPB_ID  input  DATA_W  source operand B.
REQ-009 SHALL have port IMM_ID  input  DATA_W  sign-extended immediate.
REQ-010 SHALL have port DEST_REG_INDEX_ID  input  5  destination register.
REQ-011 SHALL have port DEST_REG_WRITE_EN_ID  input  1  register write enable.
REQ-012 SHALL have port VALID_ID  input  1  instruction present.
REQ-013 SHALL have port FLUSH  input  1  kill the instruction being accepted this cycle.
REQ-014 SHALL have ports CTRL_EX (4), RES_EX (DATA_W), REG_DATA_EX (DATA_W), DEST_REG_INDEX_EX (5), DEST_REG_WRITE_EN_EX (1), VALID_EX (1), all outputs, registered, feeding memory access.
REQ-015 SHALL have port STALL_EX  output  1  combinational; upstream holds all *_ID inputs while high.

Function
REQ-016 Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, MUL 0111, LOAD 1100, STORE 1110, NOP 1111; all others execute as NOP.
REQ-017 ADD/SUB/logic SHALL compute on OPA_ID, OPB_ID modulo 2^DATA_W, carry discarded.
REQ-018 SLL/SRL SHALL shift OPA_ID by OPB_ID[3:0], zero fill.
REQ-019 LOAD/STORE SHALL set RES_EX = OPA_ID + IMM_ID and REG_DATA_EX = OPB_ID.
REQ-020 REG_DATA_EX SHALL equal OPB_ID for every opcode.
REQ-021 Single-cycle ops SHALL appear on *_EX outputs one clock after acceptance (latency 1).
REQ-022 An instruction is accepted on a rising edge with VALID_ID=1 and STALL_EX=0.
REQ-023 MUL SHALL use FSM IDLE -> BUSY -> DONE -> IDLE; IDLE->BUSY on accepting MUL, BUSY lasts MUL_CYCLES cycles, DONE lasts one cycle.
REQ-024 MUL result SHALL be the low DATA_W bits of the unsigned product, on *_EX at the DONE->IDLE edge (latency MUL_CYCLES+2).
REQ-025 STALL_EX SHALL be high in BUSY and DONE, and in IDLE when VALID_ID=1 and CTRL_ID=MUL, else low.
REQ-026 While stalled, VALID_EX SHALL be 0 (bubble) and CTRL_EX SHALL be NOP.
REQ-027 With no accepted instruction, VALID_EX=0, DEST_REG_WRITE_EN_EX=0, CTRL_EX=NOP on the next edge.
REQ-028 FLUSH with VALID_ID=1 in IDLE SHALL produce a bubble; a flushed MUL SHALL NOT enter BUSY.
REQ-029 FLUSH during BUSY/DONE SHALL abort the multiply, return to IDLE next edge, emit no result.
REQ-030 Operand values SHALL be captured at acceptance; input changes during BUSY SHALL not affect the product.
REQ-031 DEST_REG_WRITE_EN_EX SHALL be forced 0 for STORE and NOP regardless of input.

Reset
REQ-032 rst SHALL immediately force FSM=IDLE, VALID_EX=0, DEST_REG_WRITE_EN_EX=0, CTRL_EX=NOP(1111), RES_EX=0, REG_DATA_EX=0, DEST_REG_INDEX_EX=0.
REQ-033 rst mid-multiply SHALL discard the operation; first acceptance is allowed on the first edge after rst deasserts.

Structure
REQ-034 Opcode constants and FSM state encoding SHALL live in shared package core_pkg, also used by decode and memory access.
REQ-035 The iterative multiplier SHALL be sub-module ex_multiplier (start, operands, busy, done, product).

Verification
REQ-036 ADD 0x7FFF+0x0001 -> next cycle RES_EX=0x8000, VALID_EX=1.
REQ-037 SUB 0x0000-0x0001 -> RES_EX=0xFFFF; SLL 0x0001 by 0x0013 -> RES_EX=0x0008.
REQ-038 STORE OPA=0x1000, IMM=0xFFFC, OPB=0xBEEF -> RES_EX=0x0FFC, REG_DATA_EX=0xBEEF, DEST_REG_WRITE_EN_EX=0.
REQ-039 MUL 0x0123x0x0010 -> STALL_EX high 18 cycles, RES_EX=0x1230 with VALID_EX=1 at cycle 18, bubbles before.
REQ-040 MUL 0x00FF x 0x0101, FLUSH at BUSY cycle 5 -> no VALID_EX pulse, STALL_EX low next cycle.
REQ-041 rst asserted at BUSY cycle 3 -> outputs at reset values immediately; ADD accepted after release completes in 1 cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Opcode and multiply-FSM encodings shared by the decode, execute and memory-access stages.
package core_pkg;

  localparam int unsigned CTRL_W    = 4;
  localparam int unsigned REG_IDX_W = 5;

  typedef enum logic [CTRL_W-1:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_MUL   = 4'b0111,
    OP_LOAD  = 4'b1100,
    OP_STORE = 4'b1110,
    OP_NOP   = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Undefined opcodes travel down the pipe as NOP.
  function automatic logic [CTRL_W-1:0] canon_op(input logic [CTRL_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_MUL,
      OP_LOAD, OP_STORE, OP_NOP: canon_op = op;
      default:                   canon_op = OP_NOP;
    endcase
  endfunction

  function automatic logic writes_reg(input logic [CTRL_W-1:0] op);
    writes_reg = !((op == OP_STORE) || (op == OP_NOP));
  endfunction

endpackage

// File: rtl/ex_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low DATA_W bits of the product.
module ex_multiplier
  import core_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

  mul_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MUL_IDLE;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
            state   <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (abort) begin
            state <= MUL_IDLE;
          end else begin
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(MUL_CYCLES - 1)) state <= MUL_DONE;
          end
        end
        MUL_DONE: state <= MUL_IDLE;
        default:  state <= MUL_IDLE;
      endcase
    end
  end

  assign busy = (state == MUL_BUSY);
  assign done = (state == MUL_DONE);

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU/address ops plus a stalling iterative multiply.
module execute_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        CTRL_ID,
  input  logic [DATA_W-1:0] OPA_ID,
  input  logic [DATA_W-1:0] OPB_ID,
  input  logic [DATA_W-1:0] IMM_ID,
  input  logic [4:0]        DEST_REG_INDEX_ID,
  input  logic              DEST_REG_WRITE_EN_ID,
  input  logic              VALID_ID,
  input  logic              FLUSH,
  output logic [3:0]        CTRL_EX,
  output logic [DATA_W-1:0] RES_EX,
  output logic [DATA_W-1:0] REG_DATA_EX,
  output logic [4:0]        DEST_REG_INDEX_EX,
  output logic              DEST_REG_WRITE_EN_EX,
  output logic              VALID_EX,
  output logic              STALL_EX
);

  logic              mul_busy;
  logic              mul_done;
  logic              mul_start;
  logic              is_mul_c;
  logic [DATA_W-1:0] mul_product;
  logic [DATA_W-1:0] alu_res_c;
  logic [DATA_W-1:0] mul_opb;
  logic [4:0]        mul_dest;
  logic              mul_we;
  logic [3:0]        op_c;

  assign is_mul_c  = VALID_ID && (CTRL_ID == OP_MUL);
  assign mul_start = is_mul_c && !FLUSH && !mul_busy && !mul_done;
  assign STALL_EX  = mul_busy || mul_done || is_mul_c;
  assign op_c      = canon_op(CTRL_ID);

  ex_multiplier #(
    .DATA_W     (DATA_W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .abort   (FLUSH),
    .a       (OPA_ID),
    .b       (OPB_ID),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle result; loads and stores form their address here.
  always_comb begin
    alu_res_c = '0;
    case (CTRL_ID)
      OP_ADD:            alu_res_c = OPA_ID + OPB_ID;
      OP_SUB:            alu_res_c = OPA_ID - OPB_ID;
      OP_AND:            alu_res_c = OPA_ID & OPB_ID;
      OP_OR:             alu_res_c = OPA_ID | OPB_ID;
      OP_XOR:            alu_res_c = OPA_ID ^ OPB_ID;
      OP_SLL:            alu_res_c = OPA_ID << OPB_ID[3:0];
      OP_SRL:            alu_res_c = OPA_ID >> OPB_ID[3:0];
      OP_LOAD, OP_STORE: alu_res_c = OPA_ID + IMM_ID;
      default:           alu_res_c = '0;
    endcase
  end

  // Default is a bubble; data fields hold their last value when nothing issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      CTRL_EX              <= OP_NOP;
      RES_EX               <= '0;
      REG_DATA_EX          <= '0;
      DEST_REG_INDEX_EX    <= '0;
      DEST_REG_WRITE_EN_EX <= 1'b0;
      VALID_EX             <= 1'b0;
      mul_opb              <= '0;
      mul_dest             <= '0;
      mul_we               <= 1'b0;
    end else begin
      VALID_EX             <= 1'b0;
      DEST_REG_WRITE_EN_EX <= 1'b0;
      CTRL_EX              <= OP_NOP;
      if (mul_start) begin
        mul_opb  <= OPB_ID;
        mul_dest <= DEST_REG_INDEX_ID;
        mul_we   <= DEST_REG_WRITE_EN_ID;
      end
      if (mul_done) begin
        if (!FLUSH) begin
          VALID_EX             <= 1'b1;
          CTRL_EX              <= OP_MUL;
          RES_EX               <= mul_product;
          REG_DATA_EX          <= mul_opb;
          DEST_REG_INDEX_EX    <= mul_dest;
          DEST_REG_WRITE_EN_EX <= mul_we;
        end
      end else if (!mul_busy && VALID_ID && !FLUSH && !is_mul_c) begin
        VALID_EX             <= 1'b1;
        CTRL_EX              <= op_c;
        RES_EX               <= alu_res_c;
        REG_DATA_EX          <= OPB_ID;
        DEST_REG_INDEX_EX    <= DEST_REG_INDEX_ID;
        DEST_REG_WRITE_EN_EX <= DEST_REG_WRITE_EN_ID && writes_reg(op_c);
      end
    end
  end

endmodule
